// File: rtl/ws2812_bit_decoder.sv
// WS2812 bit decoder: classifies high-pulse lengths into bits, assembles MSB-first GRB pixels,
// and reports latch gaps and malformed pulses as single-cycle registered strobes.
package ws2812_pkg;
    typedef struct packed {
        logic rising;
        logic falling;
    } control_path_t;

    typedef struct packed {
        logic [9:0] counter;
    } decoder_input_t;
endpackage

module ws2812_bit_decoder
    import ws2812_pkg::*;
#(
    parameter int MIN_HIGH      = 2,
    parameter int BIT_THRESHOLD = 6,
    parameter int MAX_HIGH      = 14,
    parameter int RESET_TICKS   = 500,
    parameter int IDX_W         = 10
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  control_path_t        i_control,
    input  decoder_input_t       i_decoder_input,
    output logic [23:0]          o_pixel,
    output logic                 o_pixel_valid,
    output logic [IDX_W-1:0]     o_pixel_index,
    output logic                 o_frame_end,
    output logic                 o_bit_error
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HIGH  = 2'd1;
    localparam logic [1:0] ST_LOW   = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    localparam logic [9:0] MIN_C    = 10'(MIN_HIGH);
    localparam logic [9:0] THRESH_C = 10'(BIT_THRESHOLD);
    localparam logic [9:0] MAX_C    = 10'(MAX_HIGH);
    localparam logic [9:0] RESET_C  = 10'(RESET_TICKS);

    logic [1:0]       state_q, state_d;
    logic [23:0]      shift_q, shift_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             level_q, level_d;
    logic [23:0]      pixel_q, pixel_d;
    logic [IDX_W-1:0] pixel_idx_q, pixel_idx_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic             frame_end_q, frame_end_d;
    logic             bit_error_q, bit_error_d;

    logic       rise;
    logic       fall;
    logic [9:0] cnt;
    logic       gap;

    assign rise = i_control.rising;
    assign fall = i_control.falling;
    assign cnt  = i_decoder_input.counter;
    assign gap  = (cnt >= RESET_C);

    function automatic logic len_legal(input logic [9:0] len);
        return (len >= MIN_C) && (len <= MAX_C);
    endfunction

    function automatic logic len_is_one(input logic [9:0] len);
        return (len >= THRESH_C);
    endfunction

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        idx_d         = idx_q;
        level_d       = level_q;
        pixel_d       = pixel_q;
        pixel_idx_d   = pixel_idx_q;
        pixel_valid_d = 1'b0;
        frame_end_d   = 1'b0;
        bit_error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A same-cycle rise+fall while idle is line noise before any frame; ignore it.
                if (rise && !fall) begin
                    state_d   = ST_HIGH;
                    idx_d     = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else if (fall && !rise) begin
                    bit_error_d = 1'b1;
                    level_d     = 1'b0;
                    state_d     = ST_ERROR;
                end
            end

            ST_HIGH: begin
                if (rise) begin
                    bit_error_d = 1'b1;
                    level_d     = 1'b1;
                    state_d     = ST_ERROR;
                end else if (fall) begin
                    if (!len_legal(cnt)) begin
                        bit_error_d = 1'b1;
                        level_d     = 1'b0;
                        state_d     = ST_ERROR;
                    end else begin
                        state_d = ST_LOW;
                        if (bit_cnt_q == 5'd23) begin
                            pixel_d       = {shift_q[22:0], len_is_one(cnt)};
                            pixel_idx_d   = idx_q;
                            pixel_valid_d = 1'b1;
                            idx_d         = idx_q + IDX_W'(1);
                            bit_cnt_d     = '0;
                            shift_d       = '0;
                        end else begin
                            shift_d   = {shift_q[22:0], len_is_one(cnt)};
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else if (cnt[9]) begin
                    // Counter saturated with the line still high: stuck line.
                    bit_error_d = 1'b1;
                    level_d     = 1'b1;
                    state_d     = ST_ERROR;
                end
            end

            ST_LOW: begin
                if (fall) begin
                    bit_error_d = 1'b1;
                    level_d     = 1'b0;
                    state_d     = ST_ERROR;
                end else if (rise) begin
                    state_d = ST_HIGH;
                end else if (gap) begin
                    frame_end_d = 1'b1;
                    bit_error_d = (bit_cnt_q != 5'd0);
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                // ERROR: bit data is ignored; only the line level is followed until a gap.
                if (rise && fall) begin
                    bit_error_d = 1'b1;
                end else if (rise) begin
                    level_d = 1'b1;
                end else if (fall) begin
                    level_d = 1'b0;
                end else if (!level_q && gap) begin
                    frame_end_d = 1'b1;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            idx_q         <= '0;
            level_q       <= 1'b0;
            pixel_q       <= '0;
            pixel_idx_q   <= '0;
            pixel_valid_q <= 1'b0;
            frame_end_q   <= 1'b0;
            bit_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            idx_q         <= idx_d;
            level_q       <= level_d;
            pixel_q       <= pixel_d;
            pixel_idx_q   <= pixel_idx_d;
            pixel_valid_q <= pixel_valid_d;
            frame_end_q   <= frame_end_d;
            bit_error_q   <= bit_error_d;
        end
    end

    assign o_pixel       = pixel_q;
    assign o_pixel_valid = pixel_valid_q;
    assign o_pixel_index = pixel_idx_q;
    assign o_frame_end   = frame_end_q;
    assign o_bit_error   = bit_error_q;

endmodule
